// File: rtl/gs_pkg.sv
// Shared definitions for the grayscale shift interface: command codes, window
// tracker states and word/plane sizing used by both sides of the link.
package gs_pkg;

    localparam int NB_PLANES_DEF = 9;
    localparam int WORD_BITS     = 48;
    localparam int PLANE_WIDTH   = $clog2(NB_PLANES_DEF);
    localparam int LAT_CNT_W     = 3;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_WRTGS = 3'd1,
        CMD_LATGS = 3'd3,
        CMD_BAD   = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        LAT_SHIFT  = 2'd0,
        LAT_LATCH  = 2'd1,
        LAT_DECODE = 2'd2
    } lat_state_e;

    function automatic cmd_e classify_cmd(input logic [LAT_CNT_W-1:0] edges);
        case (edges)
            3'd1:    return CMD_WRTGS;
            3'd3:    return CMD_LATGS;
            default: return CMD_BAD;
        endcase
    endfunction

endpackage

// File: rtl/gs_lat_decoder.sv
// LAT window tracker: counts SCLK rising edges seen with LAT high and classifies
// the window as WRTGS, LATGS or an illegal command when LAT falls.
module gs_lat_decoder
    import gs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sclk_rise_i,
    input  logic lat_i,
    output logic close_o,
    output cmd_e cmd_o,
    output logic err_cmd_o
);

    lat_state_e           state_q, state_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    cmd_e                 cmd_q, cmd_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LAT_SHIFT;
            lat_cnt_q <= '0;
            cmd_q     <= CMD_NONE;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            cmd_q     <= cmd_d;
        end
    end

    // LATCH means LAT was high on the previous clk, so LATCH with LAT low is the falling edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            LAT_SHIFT:  if (lat_i) state_d = LAT_LATCH;
            LAT_LATCH:  if (!lat_i) state_d = LAT_DECODE;
            LAT_DECODE: state_d = lat_i ? LAT_LATCH : LAT_SHIFT;
            default:    state_d = LAT_SHIFT;
        endcase
    end

    always_comb begin
        close_o   = (state_q == LAT_LATCH) && !lat_i;
        cmd_o     = classify_cmd(lat_cnt_q);
        err_cmd_o = (state_q == LAT_DECODE) && (cmd_q == CMD_BAD);
        cmd_d     = close_o ? cmd_o : cmd_q;
        lat_cnt_d = close_o ? '0 : lat_cnt_q;
        if (sclk_rise_i && lat_i && (lat_cnt_d != '1)) begin
            lat_cnt_d = lat_cnt_d + LAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/gs_shift_receiver.sv
// Driver-side receiver of the grayscale shift link: deserialises SIN into bit-plane
// words and turns WRTGS/LATGS commands into word writes and frame-done pulses.
module gs_shift_receiver
    import gs_pkg::*;
#(
    parameter  int NB_LEDS_PER_GROUP = WORD_BITS / 3,
    parameter  int NB_PLANES         = NB_PLANES_DEF,
    localparam int W                 = 3 * NB_LEDS_PER_GROUP,
    localparam int PW                = (NB_PLANES == NB_PLANES_DEF) ? PLANE_WIDTH : $clog2(NB_PLANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SCLK,
    input  logic          SIN,
    input  logic          LAT,
    output logic          word_valid,
    output logic [PW-1:0] word_plane,
    output logic [W-1:0]  word_data,
    output logic          frame_done,
    output logic          err_len,
    output logic          err_cmd,
    output logic          err_plane
);

    localparam int            CW        = $clog2(W + 2);
    localparam logic [CW-1:0] BITS_FULL = CW'(W);
    localparam logic [CW-1:0] BITS_SAT  = CW'(W + 1);
    localparam logic [PW-1:0] PLANE_TOP = PW'(NB_PLANES - 1);

    logic          sclk_q;
    logic          sclk_rise;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] plane_q, plane_d;
    logic          word_valid_q, word_valid_d;
    logic [PW-1:0] word_plane_q, word_plane_d;
    logic [W-1:0]  word_data_q, word_data_d;
    logic          frame_done_q, frame_done_d;
    logic          err_len_q, err_len_d;
    logic          err_plane_q, err_plane_d;
    logic          close;
    cmd_e          cmd;
    logic          len_ok;

    assign sclk_rise = SCLK & ~sclk_q;

    gs_lat_decoder u_lat_decoder (
        .clk        (clk),
        .rst        (rst),
        .sclk_rise_i(sclk_rise),
        .lat_i      (LAT),
        .close_o    (close),
        .cmd_o      (cmd),
        .err_cmd_o  (err_cmd)
    );

    // NOTE: the shift register is reset too, so bits of an interrupted word never remain observable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q       <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            plane_q      <= PLANE_TOP;
            word_valid_q <= 1'b0;
            word_plane_q <= '0;
            word_data_q  <= '0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_plane_q  <= 1'b0;
        end else begin
            sclk_q       <= SCLK;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            plane_q      <= plane_d;
            word_valid_q <= word_valid_d;
            word_plane_q <= word_plane_d;
            word_data_q  <= word_data_d;
            frame_done_q <= frame_done_d;
            err_len_q    <= err_len_d;
            err_plane_q  <= err_plane_d;
        end
    end

    // A bit arriving on the closing clk starts the next word; the word itself comes from shreg_q.
    always_comb begin
        shreg_d = sclk_rise ? {shreg_q[W-2:0], SIN} : shreg_q;
        bit_cnt_d = close ? '0 : bit_cnt_q;
        if (sclk_rise && (bit_cnt_d != BITS_SAT)) begin
            bit_cnt_d = bit_cnt_d + CW'(1);
        end

        len_ok       = (bit_cnt_q == BITS_FULL);
        plane_d      = plane_q;
        word_valid_d = 1'b0;
        word_plane_d = word_plane_q;
        word_data_d  = word_data_q;
        frame_done_d = 1'b0;
        err_len_d    = 1'b0;
        err_plane_d  = 1'b0;

        if (close) begin
            case (cmd)
                CMD_WRTGS: begin
                    if (!len_ok) begin
                        err_len_d = 1'b1;
                    end else if (plane_q != '0) begin
                        word_valid_d = 1'b1;
                        word_plane_d = plane_q;
                        word_data_d  = shreg_q;
                        plane_d      = plane_q - PW'(1);
                    end else begin
                        err_plane_d = 1'b1;
                    end
                end
                CMD_LATGS: begin
                    frame_done_d = 1'b1;
                    plane_d      = PLANE_TOP;
                    if (!len_ok) begin
                        err_len_d = 1'b1;
                    end else begin
                        word_valid_d = 1'b1;
                        word_plane_d = plane_q;
                        word_data_d  = shreg_q;
                        err_plane_d  = (plane_q != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_valid = word_valid_q;
    assign word_plane = word_plane_q;
    assign word_data  = word_data_q;
    assign frame_done = frame_done_q;
    assign err_len    = err_len_q;
    assign err_plane  = err_plane_q;

endmodule
